knn_topk_select: RTL and testbench
==================================

# knn_topk_select

Streaming k-nearest-neighbour selector that sits directly downstream of the Euclidean distance calculator. It accepts one candidate per cycle, as a distance (IEEE-754 single, non-negative) plus a training-vector index, and maintains a sorted list of the K smallest distances seen in the current query. When the query's final candidate arrives, it drains the ranked list over a valid/ready stream to the vote/classify stage. It then clears itself for the next query.

## Interface
- VARWIDTH, 32, distance word width (IEEE-754 single)
- K, 8, number of nearest neighbours kept (2..32)
- IDXWIDTH, 16, candidate index width
- clk  input  1  sole clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous abort: empty the list, return to COLLECT
- in_valid  input  1  candidate present
- in_dist  input  VARWIDTH  candidate distance
- in_idx  input  IDXWIDTH  candidate index
- in_last  input  1  candidate is final of query (qualified by in_valid)
- in_ready  output  1  block accepts candidate this cycle
- out_valid  output  1  ranked entry present
- out_ready  input  1  consumer takes entry
- out_dist  output  VARWIDTH  ranked distance (rank 0 = nearest)
- out_idx  output  IDXWIDTH  ranked index
- out_rank  output  $clog2(K)  rank of current entry
- out_last  output  1  final entry of drain (rank = count-1)
- count  output  $clog2(K+1)  occupied slots, saturates at K

## Operation
- Storage: K slots {dist, idx}, kept sorted ascending. Empty slot: dist = all-ones, idx = 0.
- Compare: distances are compared as unsigned VARWIDTH-bit integers, which orders non-negative floats correctly. An input with the sign bit set is clamped to 0 before compare/store. NaN patterns sort above +inf and are kept only if slots remain.
- Insert (single cycle, parallel): pos = number of occupied slots with dist <= in_dist. Slots at pos..K-2 shift down one and the new entry is written at pos. The entry in slot K-1 falls off.
- Ties: a new entry goes after existing equal distances, so the earlier candidate ranks higher.
- When full (count = K) and in_dist >= slot[K-1].dist: the candidate is accepted (handshake completes) and discarded.
- FSM states:
  - COLLECT: in_ready = 1, out_valid = 0. A handshake with in_last = 1 inserts and moves to DRAIN.
  - DRAIN: in_ready = 0. out_valid = 1, presenting slot[rd_ptr]. On each out handshake rd_ptr++. The handshake at rd_ptr = count-1 (out_last = 1) empties all slots, sets count = 0 and rd_ptr = 0, and moves to COLLECT.
- clr: empties the list, sets count = 0 and rd_ptr = 0, and moves to COLLECT. clr has priority over a simultaneous input or output handshake; that handshake is ignored.

## Timing
- Reset values: state COLLECT, all slots empty, count 0, rd_ptr 0. Outputs during and after reset: in_ready 1, out_valid 0, out_dist all-ones, out_idx 0, out_rank 0, out_last 0.
- Insert latency: a candidate accepted at edge N is reflected in slots and count after edge N.
- Drain start: last candidate accepted at edge N gives out_valid = 1 in cycle N+1 with rank 0.
- Drain rate: one entry per cycle while out_ready = 1. With out_ready = 0, all out_* signals hold stable.
- Drain end: the final handshake at edge M gives in_ready = 1 in cycle M+1 with an empty list. Minimum query-to-query gap is count cycles.
- Reset asserted mid-COLLECT or mid-DRAIN: immediate return to reset values; no partial output.
- out_* are registered or derived from registered state only; no combinational path from in_* to out_*.

## Test plan
All scenarios use K = 4.
- Reset/idle: assert rst low mid-stream -> in_ready = 1, out_valid = 0, count = 0, out_dist = 0xFFFFFFFF immediately and after release.
- Basic sort: dists 5.0, 3.0, 9.0, 1.0 with idx 0..3, last on 4th -> drain (1.0, 3), (3.0, 1), (5.0, 0), (9.0, 2); out_last only on rank 3; in_ready high the cycle after.
- Overflow eviction: dists 10, 20, 30, 40, 5, 50 (idx 0..5), last on 50 -> drain idx 4, 0, 1, 2; count = 4.
- Ties/discard: four 7.0 (idx 0..3) then 7.0 idx 4 last -> drain idx 0, 1, 2, 3; idx 4 discarded but handshake completed.
- Backpressure + clr: hold out_ready low 3 cycles at rank 1 -> outputs stable; then pulse clr together with an out handshake -> count = 0, COLLECT, no further out_valid.
- Sign clamp/partial: 0xBF800000 idx 9 then 2.0 idx 1, last -> drain (0x00000000, 9), (2.0, 1); count = 2; out_last on rank 1.

Source files
------------

// File: rtl/knn_topk_select.sv
// Streaming top-K selector: keeps the K smallest {dist, idx} pairs of a query in a
// sorted slot array, then drains them in rank order over a valid/ready stream.
module knn_topk_select #(
    parameter int VARWIDTH = 32,
    parameter int K        = 8,
    parameter int IDXWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [VARWIDTH-1:0]    in_dist,
    input  logic [IDXWIDTH-1:0]    in_idx,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VARWIDTH-1:0]    out_dist,
    output logic [IDXWIDTH-1:0]    out_idx,
    output logic [$clog2(K)-1:0]   out_rank,
    output logic                   out_last,
    output logic [$clog2(K+1)-1:0] count
);

    localparam int RW = $clog2(K);
    localparam int CW = $clog2(K+1);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [VARWIDTH-1:0] dist_q [K];
    logic [VARWIDTH-1:0] dist_d [K];
    logic [IDXWIDTH-1:0] idx_q  [K];
    logic [IDXWIDTH-1:0] idx_d  [K];
    logic [CW-1:0]       count_q, count_d;
    logic [RW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       pos;
    logic [VARWIDTH-1:0] cand;

    // Negative distances can only come from rounding upstream; treat them as zero.
    function automatic logic [VARWIDTH-1:0] clamp_dist(input logic [VARWIDTH-1:0] d);
        return d[VARWIDTH-1] ? '0 : d;
    endfunction

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DRAIN);
    assign out_dist  = dist_q[rd_ptr_q];
    assign out_idx   = idx_q[rd_ptr_q];
    assign out_rank  = rd_ptr_q;
    assign out_last  = out_valid && (CW'(rd_ptr_q) == count_q - CW'(1));
    assign count     = count_q;

    always_comb begin
        state_d  = state_q;
        dist_d   = dist_q;
        idx_d    = idx_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        cand     = clamp_dist(in_dist);

        // Insert position: occupied slots with dist <= cand, so ties land after
        // earlier equal entries. pos == K means the candidate is discarded.
        pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((CW'(i) < count_q) && (dist_q[i] <= cand)) begin
                pos = pos + CW'(1);
            end
        end

        if (clr) begin
            for (int i = 0; i < K; i++) begin
                dist_d[i] = '1;
                idx_d[i]  = '0;
            end
            count_d  = '0;
            rd_ptr_d = '0;
            state_d  = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        if (pos == '0) begin
                            dist_d[0] = cand;
                            idx_d[0]  = in_idx;
                        end
                        for (int i = 1; i < K; i++) begin
                            if (CW'(i) == pos) begin
                                dist_d[i] = cand;
                                idx_d[i]  = in_idx;
                            end else if (CW'(i) > pos) begin
                                dist_d[i] = dist_q[i-1];
                                idx_d[i]  = idx_q[i-1];
                            end
                        end
                        if (count_q != CW'(K)) begin
                            count_d = count_q + CW'(1);
                        end
                        if (in_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            for (int i = 0; i < K; i++) begin
                                dist_d[i] = '1;
                                idx_d[i]  = '0;
                            end
                            count_d  = '0;
                            rd_ptr_d = '0;
                            state_d  = COLLECT;
                        end else begin
                            rd_ptr_d = rd_ptr_q + RW'(1);
                        end
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '1;
                idx_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            dist_q   <= dist_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_knn_topk_select.sv
// Directed bench for knn_topk_select with K = 4.
module tb_knn_topk_select;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_dist;
    logic [15:0] in_idx;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dist;
    logic [15:0] out_idx;
    logic [1:0]  out_rank;
    logic        out_last;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    knn_topk_select #(.VARWIDTH(32), .K(4), .IDXWIDTH(16)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_dist(in_dist), .in_idx(in_idx), .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
        .out_idx(out_idx), .out_rank(out_rank), .out_last(out_last), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one candidate for one cycle; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [15:0] idx, input logic last);
        in_valid = 1'b1;
        in_dist  = d;
        in_idx   = idx;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_dist !== 32'hFFFFFFFF
            || out_idx !== 16'd0 || out_rank !== 2'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: rdy=%b vld=%b cnt=%0d dist=%h idx=%0d rank=%0d last=%b, want 1 0 0 ffffffff 0 0 0",
                     in_ready, out_valid, count, out_dist, out_idx, out_rank, out_last);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_dist !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_release: rdy=%b vld=%b cnt=%0d dist=%h, want 1 0 0 ffffffff",
                     in_ready, out_valid, count, out_dist);
        end
        // Mid-COLLECT reset
        send(32'h40000000, 16'd5, 1'b0);
        send(32'h3F800000, 16'd6, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset_count: got %0d want 2", count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_dist !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_mid_collect: rdy=%b vld=%b cnt=%0d dist=%h, want 1 0 0 ffffffff",
                     in_ready, out_valid, count, out_dist);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        // Mid-DRAIN reset
        send(32'h40400000, 16'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 16'd7) begin
            failures++;
            $display("FAIL pre_reset_drain: vld=%b idx=%0d want 1 7", out_valid, out_idx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_dist !== 32'hFFFFFFFF
            || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drain: rdy=%b vld=%b cnt=%0d dist=%h last=%b, want 1 0 0 ffffffff 0",
                     in_ready, out_valid, count, out_dist, out_last);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sort();
        logic [31:0] ed [4] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41100000};
        logic [15:0] ei [4] = '{16'd3, 16'd1, 16'd0, 16'd2};
        send(32'h40A00000, 16'd0, 1'b0);
        send(32'h40400000, 16'd1, 1'b0);
        send(32'h41100000, 16'd2, 1'b0);
        send(32'h3F800000, 16'd3, 1'b1);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_count: cnt=%0d rdy=%b want 4 0", count, in_ready);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_dist !== ed[r] || out_idx !== ei[r]
                || out_rank !== 2'(r) || out_last !== (r == 3)) begin
                failures++;
                $display("FAIL basic_rank%0d: vld=%b dist=%h idx=%0d rank=%0d last=%b, want 1 %h %0d %0d %b",
                         r, out_valid, out_dist, out_idx, out_rank, out_last, ed[r], ei[r], r, (r == 3));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_dist !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL basic_end: rdy=%b vld=%b cnt=%0d dist=%h, want 1 0 0 ffffffff",
                     in_ready, out_valid, count, out_dist);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ed [4] = '{32'h40A00000, 32'h41200000, 32'h41A00000, 32'h41F00000};
        logic [15:0] ei [4] = '{16'd4, 16'd0, 16'd1, 16'd2};
        send(32'h41200000, 16'd0, 1'b0);
        send(32'h41A00000, 16'd1, 1'b0);
        send(32'h41F00000, 16'd2, 1'b0);
        send(32'h42200000, 16'd3, 1'b0);
        send(32'h40A00000, 16'd4, 1'b0);
        send(32'h42480000, 16'd5, 1'b1);
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL overflow_count: got %0d want 4", count);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_dist !== ed[r] || out_idx !== ei[r]
                || out_rank !== 2'(r) || out_last !== (r == 3)) begin
                failures++;
                $display("FAIL overflow_rank%0d: vld=%b dist=%h idx=%0d last=%b, want 1 %h %0d %b",
                         r, out_valid, out_dist, out_idx, out_last, ed[r], ei[r], (r == 3));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL overflow_end: rdy=%b vld=%b cnt=%0d want 1 0 0", in_ready, out_valid, count);
        end
    endtask

    task automatic test_ties_discard();
        for (int i = 0; i < 4; i++) begin
            send(32'h40E00000, 16'(i), 1'b0);
        end
        in_valid = 1'b1;
        in_dist  = 32'h40E00000;
        in_idx   = 16'd4;
        in_last  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ties_accept: in_ready=%b want 1 while full", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (count !== 3'd4 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ties_count: cnt=%0d vld=%b want 4 1", count, out_valid);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_dist !== 32'h40E00000 || out_idx !== 16'(r)
                || out_last !== (r == 3)) begin
                failures++;
                $display("FAIL ties_rank%0d: vld=%b dist=%h idx=%0d last=%b, want 1 40e00000 %0d %b",
                         r, out_valid, out_dist, out_idx, out_last, r, (r == 3));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ties_end: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure_clr();
        send(32'h40A00000, 16'd0, 1'b0);
        send(32'h40400000, 16'd1, 1'b0);
        send(32'h41100000, 16'd2, 1'b0);
        send(32'h3F800000, 16'd3, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_rank !== 2'd1 || out_dist !== 32'h40400000
                || out_idx !== 16'd1 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d: vld=%b rank=%0d dist=%h idx=%0d last=%b, want 1 1 40400000 1 0",
                         c, out_valid, out_rank, out_dist, out_idx, out_last);
            end
        end
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_rank !== 2'd0
            || out_dist !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL clr_effect: cnt=%0d vld=%b rdy=%b rank=%0d dist=%h, want 0 0 1 0 ffffffff",
                     count, out_valid, in_ready, out_rank, out_dist);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL clr_quiet%0d: out_valid=%b want 0", c, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_sign_clamp();
        logic [31:0] ed [2] = '{32'h00000000, 32'h40000000};
        logic [15:0] ei [2] = '{16'd9, 16'd1};
        send(32'hBF800000, 16'd9, 1'b0);
        send(32'h40000000, 16'd1, 1'b1);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL clamp_count: got %0d want 2", count);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_dist !== ed[r] || out_idx !== ei[r]
                || out_rank !== 2'(r) || out_last !== (r == 1)) begin
                failures++;
                $display("FAIL clamp_rank%0d: vld=%b dist=%h idx=%0d rank=%0d last=%b, want 1 %h %0d %0d %b",
                         r, out_valid, out_dist, out_idx, out_rank, out_last, ed[r], ei[r], r, (r == 1));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL clamp_end: rdy=%b vld=%b cnt=%0d want 1 0 0", in_ready, out_valid, count);
        end
    endtask

    initial begin
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sort();
        test_overflow();
        test_ties_discard();
        test_backpressure_clr();
        test_sign_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
